// File: rtl/pulse_sched_pkg.sv
// Shared types for the pulse scheduler.
//   state_t : scheduler FSM states
//     IDLE  - line free, nothing pending
//     PULSE - pulse output high, width counter running
//     GAP   - mandatory low gap after a pulse
package pulse_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches the request vector starting at ptr and moving upward (mod N);
// the first set bit wins. The pointer register lives in the caller.
// Ports:
//   req       in  N   request vector
//   ptr       in  IW  index at which the search starts
//   valid     out 1   at least one request present
//   grant_idx out IW  index of the winner (0 when !valid)
//   grant_oh  out N   one-hot winner (all zero when !valid)
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] grant_idx,
    output logic [N-1:0]  grant_oh
);

    always_comb begin
        valid     = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!valid && req[j]) begin
                valid     = 1'b1;
                grant_idx = IW'(j);
            end
        end
        grant_oh = valid ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/pulse_scheduler.sv
// Shares one registered pulse output between NUM_REQ requesters.
// Requests are latched as pending and granted round-robin; each grant
// emits one pulse of max(width,1) cycles followed by GAP_CYCLES low cycles.
// Ports:
//   clk       in  1        clock, rising edge
//   rst       in  1        asynchronous active-high reset
//   req       in  NUM_REQ  request strobes (one request per cycle high)
//   width     in  WIDTH_W  pulse length, sampled at grant (0 treated as 1)
//   pulse     out 1        shared pulse output, registered
//   pulse_id  out IW       index of current/last granted requester
//   busy      out 1        high whenever the FSM is not IDLE
//   overflow  out NUM_REQ  one-cycle flag: req[i] while pending[i] already set
module pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int WIDTH_W    = 8,
    parameter  int GAP_CYCLES = 2,
    localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int GW         = $clog2(GAP_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH_W-1:0] width,
    output logic               pulse,
    output logic [IW-1:0]      pulse_id,
    output logic               busy,
    output logic [NUM_REQ-1:0] overflow
);

    state_t             state, state_next;
    logic [NUM_REQ-1:0] pending, pending_next;
    logic [NUM_REQ-1:0] eff;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IW-1:0]      grant_idx;
    logic [IW-1:0]      ptr, ptr_next;
    logic               grant_valid;
    logic               grant_now;
    logic [WIDTH_W-1:0] cnt, cnt_next;
    logic [GW-1:0]      gcnt, gcnt_next;
    logic               pulse_next;
    logic [IW-1:0]      id_next;

    // A request arriving in the same cycle as a grant decision is grantable.
    assign eff = pending | req;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (eff),
        .ptr       (ptr),
        .valid     (grant_valid),
        .grant_idx (grant_idx),
        .grant_oh  (grant_oh)
    );

    // Grants happen from IDLE or on the last cycle of the gap, so that
    // back-to-back pulses are separated by exactly GAP_CYCLES low cycles.
    assign grant_now = grant_valid &&
                       ((state == IDLE) || ((state == GAP) && (gcnt == '0)));

    assign busy = (state != IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (grant_valid) state_next = PULSE;
            PULSE:   if (cnt == '0) state_next = GAP;
            GAP:     if (gcnt == '0) state_next = grant_valid ? PULSE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pulse_next = pulse;
        id_next    = pulse_id;
        cnt_next   = cnt;
        gcnt_next  = gcnt;
        if (grant_now) begin
            pulse_next = 1'b1;
            id_next    = grant_idx;
            cnt_next   = (width == '0) ? '0 : width - WIDTH_W'(1);
        end else begin
            unique case (state)
                PULSE: begin
                    if (cnt != '0) begin
                        cnt_next = cnt - WIDTH_W'(1);
                    end else begin
                        pulse_next = 1'b0;
                        gcnt_next  = GW'(GAP_CYCLES - 1);
                    end
                end
                GAP: begin
                    if (gcnt != '0) gcnt_next = gcnt - GW'(1);
                end
                default: pulse_next = 1'b0;
            endcase
        end

        // The granted requester's pending bit (and any same-cycle req) is consumed.
        pending_next = eff & ~(grant_now ? grant_oh : '0);

        ptr_next = ptr;
        if (grant_now) begin
            ptr_next = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse    <= 1'b0;
            pulse_id <= '0;
            overflow <= '0;
            pending  <= '0;
            ptr      <= '0;
            cnt      <= '0;
            gcnt     <= '0;
        end else begin
            pulse    <= pulse_next;
            pulse_id <= id_next;
            overflow <= req & pending;
            pending  <= pending_next;
            ptr      <= ptr_next;
            cnt      <= cnt_next;
            gcnt     <= gcnt_next;
        end
    end

endmodule
